// File: rtl/binary_to_gary_dataflow.sv
// Binary to Gray converter with a registered output stage, Gray decode of the
// registered code, and a flag for accepted samples that break Gray adjacency.
module binary_to_gary_dataflow #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] binary,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary_back,
    output logic             step_err
);

    logic [WIDTH-1:0] gray_q_reg;
    logic             out_valid_reg;
    logic             step_err_reg;
    logic             prev_valid_reg;

    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic             step_err_next;

    // Combinational Gray encode: MSB passes through, lower bits XOR their upper neighbour.
    assign gray[WIDTH-1] = binary[WIDTH-1];
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_encode
            assign gray[gi] = binary[gi+1] ^ binary[gi];
        end
    endgenerate

    // Decode bit i is the XOR of all registered Gray bits from i up to the MSB.
    // Computed per bit as a reduction so there is no chain through binary_back itself.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign binary_back[gi] = ^(gray_q_reg >> gi);
        end
    endgenerate

    // More than one differing bit means clearing the lowest set bit leaves something.
    assign diff          = gray ^ gray_q_reg;
    assign multi_bit     = |(diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1}));
    assign step_err_next = in_valid & prev_valid_reg & multi_bit;

    // Capture stage: load on accepted samples, pulse flags for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q_reg     <= '0;
            out_valid_reg  <= 1'b0;
            step_err_reg   <= 1'b0;
            prev_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            step_err_reg  <= step_err_next;
            if (in_valid) begin
                gray_q_reg     <= gray;
                prev_valid_reg <= 1'b1;
            end
        end
    end

    assign gray_q    = gray_q_reg;
    assign out_valid = out_valid_reg;
    assign step_err  = step_err_reg;

endmodule

// File: tb/tb_binary_to_gary_dataflow.sv
// Scoreboard bench for binary_to_gary_dataflow (WIDTH=4) with directed vectors.
module tb_binary_to_gary_dataflow;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] binary;
    logic       in_valid;
    logic [3:0] gray;
    logic [3:0] gray_q;
    logic       out_valid;
    logic [3:0] binary_back;
    logic       step_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] b;
        logic       e;
    } exp_t;

    exp_t sb[$];

    binary_to_gary_dataflow #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .binary      (binary),
        .in_valid    (in_valid),
        .gray        (gray),
        .gray_q      (gray_q),
        .out_valid   (out_valid),
        .binary_back (binary_back),
        .step_err    (step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%b t=%0t", name, act, $time);
        end
    endtask

    // Monitor: every presented output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 expected=0 t=%0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_gray_q", gray_q, e.g);
                chk("mon_binary_back", binary_back, e.b);
                chk("mon_step_err", {3'b0, step_err}, {3'b0, e.e});
            end
        end
    end

    // Present one accepted sample and record its expected registered response.
    task automatic send(input logic [3:0] b, input logic [3:0] g, input logic e);
        exp_t x;
        @(negedge clk);
        binary   = b;
        in_valid = 1'b1;
        x.g = g;
        x.b = b;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [3:0] cb_in  [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0100, 4'b1111};
    logic [3:0] cb_exp [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                               4'b0101, 4'b0100, 4'b0110, 4'b1000};
    logic [3:0] gray16 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] hold_in  [3] = '{4'b1010, 4'b0101, 4'b1100};
    logic [3:0] hold_exp [3] = '{4'b1111, 4'b0111, 4'b1010};

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        binary   = 4'b0110;
        in_valid = 1'b0;
        #2;
        chk("rst_gray_q", gray_q, 4'b0000);
        chk("rst_out_valid", {3'b0, out_valid}, 4'b0000);
        chk("rst_step_err", {3'b0, step_err}, 4'b0000);
        chk("rst_binary_back", binary_back, 4'b0000);
        chk("rst_gray_tracks", gray, 4'b0101);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Combinational conversion, no clock involvement.
        for (int i = 0; i < 8; i++) begin
            binary = cb_in[i];
            #1;
            chk("comb_gray", gray, cb_exp[i]);
        end

        // Full 16-value stream, counting order: every step adjacent.
        for (int i = 0; i < 16; i++) send(4'(i), gray16[i], 1'b0);

        // Step error sequence; 0111 follows Gray 1000 (two bits differ).
        send(4'b0111, 4'b0100, 1'b1);
        send(4'b0100, 4'b0110, 1'b0);
        send(4'b1111, 4'b1000, 1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("err_one_cycle", {3'b0, step_err}, 4'b0000);
        chk("idle_out_valid", {3'b0, out_valid}, 4'b0000);

        // Counting through wrap-around, then a repeat.
        send(4'b1110, 4'b1001, 1'b0);
        send(4'b1111, 4'b1000, 1'b0);
        send(4'b0000, 4'b0000, 1'b0);
        send(4'b0101, 4'b0111, 1'b1);
        send(4'b0101, 4'b0111, 1'b0);

        // Mid-stream asynchronous reset.
        send(4'b0010, 4'b0011, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gray_q", gray_q, 4'b0000);
        chk("mid_rst_out_valid", {3'b0, out_valid}, 4'b0000);
        chk("mid_rst_step_err", {3'b0, step_err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        send(4'b1111, 4'b1000, 1'b0);

        // Hold: registered state frozen while gray follows binary.
        send(4'b0011, 4'b0010, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("hold_gray_q", gray_q, 4'b0010);
            chk("hold_out_valid", {3'b0, out_valid}, 4'b0000);
            chk("hold_step_err", {3'b0, step_err}, 4'b0000);
            binary = hold_in[i];
            #1;
            chk("hold_gray", gray, hold_exp[i]);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binary_to_gary_dataflow.md
BINARY_TO_GARY_DATAFLOW -- requirements
Module: binary_to_gary_dataflow

Interface
REQ-001 Parameter WIDTH, default 4, code width in bits; SHALL be legal for any value >= 2.
REQ-002 clk  input  1  single clock; all registers SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 binary  input  WIDTH  binary-coded input word.
REQ-005 in_valid  input  1  marks binary as a sample to capture on this clock edge.
REQ-006 gray  output  WIDTH  combinational Gray code of binary.
REQ-007 gray_q  output  WIDTH  registered Gray code of the last accepted sample.
REQ-008 out_valid  output  1  registered; high for one cycle after each accepted sample.
REQ-009 binary_back  output  WIDTH  combinational Gray-to-binary decode of gray_q.
REQ-010 step_err  output  1  registered one-cycle flag: accepted Gray code is not Gray-adjacent to the previous one.

Function
REQ-011 gray SHALL equal binary XOR (binary logically shifted right by 1): MSB passes through; bit i = binary[i+1] XOR binary[i].
REQ-012 gray SHALL be purely combinational, SHALL have zero latency, and SHALL not depend on clk, rst or in_valid.
REQ-013 On a rising clk edge with in_valid=1, gray_q SHALL load the REQ-011 conversion of binary; out_valid SHALL be 1 in the following cycle.
REQ-014 On a rising clk edge with in_valid=0, gray_q SHALL hold; out_valid SHALL be 0 in the following cycle.
REQ-015 binary_back SHALL be the prefix XOR of gray_q from MSB down: bit WIDTH-1 = gray_q[WIDTH-1]; bit i = binary_back[i+1] XOR gray_q[i]; it SHALL equal the binary value last accepted.
REQ-016 An internal prev_valid flag SHALL be set by the first accepted sample after reset.
REQ-017 On an accepted sample with prev_valid=1, step_err SHALL be 1 in the following cycle if the new Gray code and the current gray_q differ in more than one bit position, and 0 otherwise.
REQ-018 A differing bit count of 0 (repeat value) or exactly 1 SHALL not raise step_err.
REQ-019 The first accepted sample after reset SHALL never raise step_err.
REQ-020 step_err SHALL be 0 in any cycle following a clk edge with in_valid=0.
REQ-021 Wrap-around from all-ones to zero (Gray 100..0 to 000..0) SHALL count as adjacent and SHALL not raise step_err.
REQ-022 Latency SHALL be one cycle from the accepting edge to gray_q, out_valid and step_err; binary_back SHALL follow gray_q combinationally.
REQ-023 There SHALL be no backpressure; every in_valid=1 edge SHALL be accepted.

Reset
REQ-024 While rst=1, the following SHALL be forced to 0 immediately, independent of clk: gray_q, out_valid, step_err and prev_valid; binary_back therefore reads 0.
REQ-025 gray SHALL continue to track binary during reset.
REQ-026 If rst asserts mid-stream, the next accepted sample after release SHALL be treated as the first sample per REQ-019.
REQ-027 A sample presented on the same edge that rst deasserts SHALL be accepted only if rst is already low at that edge.

Verification
REQ-028 Combinational sweep with WIDTH=4 SHALL produce these binary -> gray results:
  0000 -> 0000
  0001 -> 0001
  0011 -> 0010
  0010 -> 0011
  0110 -> 0101
  0111 -> 0100
  0100 -> 0110
  1111 -> 1000
REQ-029 All 16 4-bit values SHALL be streamed with in_valid=1. One cycle after each edge, gray_q SHALL equal the REQ-011 code and binary_back SHALL equal the input value. out_valid SHALL be 1 throughout.
REQ-030 The sequence 0111 then 0100 then 1111 SHALL be streamed. After 0100 (Gray 0100 -> 0110), step_err SHALL be 0. After 1111 (Gray 0110 -> 1000, 3 bits differ), step_err SHALL be 1 for exactly one cycle.
REQ-031 Counting sequences SHALL be streamed with no step_err:
  1110 -> 1111 -> 0000 (Gray 1001 -> 1000 -> 0000)
  0101 -> 0101 (repeat)
REQ-032 Mid-stream reset test: accept 0010, assert rst asynchronously between edges, release, then accept 1111. gray_q, out_valid and step_err SHALL read 0 during reset. After 1111, gray_q SHALL be 1000 and step_err SHALL be 0.
REQ-033 Hold test: accept 0011, then hold in_valid=0 for 3 cycles. gray_q SHALL hold 0010, out_valid SHALL be 0 and step_err SHALL be 0, while gray tracks binary changes immediately.
